// File: rtl/gf_clk_pkg.sv
// Shared definitions for the glitch-free divided-clock generator:
// FSM state encoding, the minimum legal divide ratio and the ratio clamp.
package gf_clk_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } gf_state_t;

   // Smallest ratio that still yields one high and one low cycle.
   localparam int MIN_DIV = 2;

   // Ratios 0 and 1 cannot form a period, so they are promoted to MIN_DIV.
   function automatic logic [31:0] clamp_div(input logic [31:0] value);
      return (value < 32'(MIN_DIV)) ? 32'(MIN_DIV) : value;
   endfunction

endpackage

// File: rtl/gf_div_counter.sv
// Modulo-N phase counter. cnt runs 0..n-1 and wraps; wrap flags the last
// cycle of a period and high flags the first n>>1 cycles (the high phase).
module gf_div_counter #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             run,
   input  logic [DIV_W-1:0] n,
   output logic             wrap,
   output logic             high
);

   logic [DIV_W-1:0] cnt;

   assign wrap = (cnt == n - DIV_W'(1));
   assign high = (cnt < (n >> 1));

   // Phase counter: cleared on ratio load, advances only while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= wrap ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/glitch_free_clkdiv_sel.sv
// Glitch-free divided clock with an N-way ratio selector.
// A ratio change lets the current period finish, holds clk_out low for
// GAP_CYC cycles, then loads the new ratio, so no runt pulse is produced.
// Optional macro GFDIV_HANDSHAKE_EN adds a sel_valid/sel_ready request
// handshake; without it sel is observed continuously.
module glitch_free_clkdiv_sel
   import gf_clk_pkg::*;
#(
   parameter  int NUM_SEL = 4,
   parameter  int DIV_W   = 8,
   parameter  int GAP_CYC = 2,
   localparam int SEL_W   = $clog2(NUM_SEL)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SEL*DIV_W-1:0] div_cfg,
`ifdef GFDIV_HANDSHAKE_EN
   input  logic                     sel_valid,
   output logic                     sel_ready,
`endif
   output logic                     clk_out,
   output logic                     clk_rise,
   output logic [SEL_W-1:0]         sel_active,
   output logic                     sw_busy,
   output logic                     sw_done
);

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   gf_state_t        state, state_next;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
   logic [DIV_W-1:0] n_div, n_div_next;
   logic [SEL_W-1:0] sel_active_next;
   logic             clk_out_next;
   logic             clk_rise_next;
   logic             sw_busy_next;
   logic             sw_done_next;
   logic             post_reset, post_reset_next;
   logic             cnt_clear, cnt_run, cnt_wrap, cnt_high;
   logic             busy_req;
   logic [SEL_W-1:0] tgt_sel;
   logic [DIV_W-1:0] cfg_slice [NUM_SEL];

   // Unpack the configuration bus into one entry per ratio index.
   generate
      for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_cfg
         assign cfg_slice[gi] = div_cfg[gi*DIV_W +: DIV_W];
      end
   endgenerate

`ifdef GFDIV_HANDSHAKE_EN
   logic             accept;
   logic [SEL_W-1:0] req_sel;

   assign sel_ready = !sw_busy;
   assign accept    = sel_valid && sel_ready;
   // A pending switch is latched once accepted and cannot be cancelled.
   assign busy_req  = sw_busy || (accept && (sel != sel_active));
   // The first load after reset takes sel directly; later loads use the
   // index captured at acceptance.
   assign tgt_sel   = post_reset ? sel : req_sel;

   // Capture the requested index at acceptance; later sel wiggles are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_sel <= '0;
      end else if (accept) begin
         req_sel <= sel;
      end
   end
`else
   // Continuous observation: a request exists while sel differs, so a
   // return to the active index before the period ends cancels it.
   assign busy_req = (sel != sel_active);
   assign tgt_sel  = sel;
`endif

   gf_div_counter #(
      .DIV_W (DIV_W)
   ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clear),
      .run   (cnt_run),
      .n     (n_div),
      .wrap  (cnt_wrap),
      .high  (cnt_high)
   );

   // Next-state and next-output logic for the LOAD/RUN/GAP sequencer.
   always_comb begin
      state_next      = state;
      gap_cnt_next    = gap_cnt;
      n_div_next      = n_div;
      sel_active_next = sel_active;
      clk_out_next    = 1'b0;
      sw_busy_next    = sw_busy;
      sw_done_next    = 1'b0;
      post_reset_next = post_reset;
      cnt_clear       = 1'b0;
      cnt_run         = 1'b0;
      case (state)
         LOAD: begin
            sel_active_next = tgt_sel;
            n_div_next      = DIV_W'(clamp_div(32'(cfg_slice[tgt_sel])));
            cnt_clear       = 1'b1;
            sw_busy_next    = 1'b0;
            sw_done_next    = !post_reset;
            post_reset_next = 1'b0;
            state_next      = RUN;
         end
         RUN: begin
            cnt_run      = 1'b1;
            clk_out_next = cnt_high;
            sw_busy_next = busy_req;
            if (cnt_wrap) begin
               if (busy_req) begin
                  state_next   = GAP;
                  gap_cnt_next = '0;
               end else begin
                  // Ratio edits on the active slice apply only at a wrap,
                  // so a running high phase is never shortened.
                  n_div_next = DIV_W'(clamp_div(32'(cfg_slice[sel_active])));
               end
            end
         end
         GAP: begin
            sw_busy_next = 1'b1;
            if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
               state_next = LOAD;
            end else begin
               gap_cnt_next = gap_cnt + GAP_W'(1);
            end
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   assign clk_rise_next = clk_out_next && !clk_out;

   // State and registered outputs; clk_out drops at once on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOAD;
         gap_cnt    <= '0;
         n_div      <= DIV_W'(MIN_DIV);
         sel_active <= '0;
         clk_out    <= 1'b0;
         clk_rise   <= 1'b0;
         sw_busy    <= 1'b0;
         sw_done    <= 1'b0;
         post_reset <= 1'b1;
      end else begin
         state      <= state_next;
         gap_cnt    <= gap_cnt_next;
         n_div      <= n_div_next;
         sel_active <= sel_active_next;
         clk_out    <= clk_out_next;
         clk_rise   <= clk_rise_next;
         sw_busy    <= sw_busy_next;
         sw_done    <= sw_done_next;
         post_reset <= post_reset_next;
      end
   end

endmodule
